// File: rtl/board_scan_renderer.sv
// Frame scanner: walks NUM_BOARDS grids cell by cell, fetches each cell's code,
// and streams one pixel per accepted handshake with border/cursor colouring.
module board_scan_renderer #(
  parameter int unsigned GRID_W      = 10,
  parameter int unsigned GRID_H      = 10,
  parameter int unsigned CELL_PX     = 8,
  parameter int unsigned NUM_BOARDS  = 2,
  parameter int unsigned X0          = 0,
  parameter int unsigned Y0          = 20,
  parameter int unsigned BOARD_PITCH = 160
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  START,
  output logic [1:0]            cell_board,
  output logic [3:0]            cell_x,
  output logic [3:0]            cell_y,
  input  logic [1:0]            cell_code,
  input  logic [NUM_BOARDS-1:0] cursor_en,
  input  logic [3:0]            cursor_x,
  input  logic [3:0]            cursor_y,
  output logic [8:0]            pix_x,
  output logic [7:0]            pix_y,
  output logic [2:0]            pix_colour,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned PW = (CELL_PX > 2) ? $clog2(CELL_PX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_FIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_board, w_board_nxt;
  logic [3:0]      r_cx, w_cx_nxt;
  logic [3:0]      r_cy, w_cy_nxt;
  logic [PW-1:0]   r_px, w_px_nxt;
  logic [PW-1:0]   r_py, w_py_nxt;
  logic [1:0]      r_code;
  logic            r_hit;

  logic            w_px_end, w_last_px, w_last_col, w_last_row, w_last_brd;
  logic [3:0]      w_en4;
  logic            w_hit, w_draw, w_border;
  logic [2:0]      w_fill;

  assign w_px_end   = (r_px == PW'(CELL_PX - 1));
  assign w_last_px  = w_px_end && (r_py == PW'(CELL_PX - 1));
  assign w_last_col = (r_cx == 4'(GRID_W - 1));
  assign w_last_row = (r_cy == 4'(GRID_H - 1));
  assign w_last_brd = (r_board == 2'(NUM_BOARDS - 1));
  assign w_en4      = 4'(cursor_en);
  assign w_hit      = w_en4[r_board] && (cursor_x == r_cx) && (cursor_y == r_cy);

  // Next-state and counter advance
  always_comb begin
    w_state_nxt = r_state;
    w_board_nxt = r_board;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_LOAD;
          w_board_nxt = '0;
          w_cx_nxt    = '0;
          w_cy_nxt    = '0;
          w_px_nxt    = '0;
          w_py_nxt    = '0;
        end
      end
      S_LOAD: w_state_nxt = S_DRAW;
      S_DRAW: begin
        if (pix_ready) begin
          if (w_last_px) begin
            w_px_nxt = '0;
            w_py_nxt = '0;
            if (w_last_col && w_last_row && w_last_brd) begin
              w_state_nxt = S_FIN;
              w_board_nxt = '0;
              w_cx_nxt    = '0;
              w_cy_nxt    = '0;
            end else begin
              w_state_nxt = S_LOAD;
              if (w_last_col) begin
                w_cx_nxt = '0;
                if (w_last_row) begin
                  w_cy_nxt    = '0;
                  w_board_nxt = r_board + 2'd1;
                end else begin
                  w_cy_nxt = r_cy + 4'd1;
                end
              end else begin
                w_cx_nxt = r_cx + 4'd1;
              end
            end
          end else if (w_px_end) begin
            w_px_nxt = '0;
            w_py_nxt = r_py + PW'(1);
          end else begin
            w_px_nxt = r_px + PW'(1);
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_board_nxt = '0;
        w_cx_nxt    = '0;
        w_cy_nxt    = '0;
        w_px_nxt    = '0;
        w_py_nxt    = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, and the per-cell snapshot taken at the end of LOAD
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_board <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_code  <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_board <= w_board_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      r_px    <= w_px_nxt;
      r_py    <= w_py_nxt;
      if (r_state == S_LOAD) begin
        r_code <= cell_code;
        r_hit  <= w_hit;
      end
    end
  end

  assign w_draw   = (r_state == S_DRAW);
  assign w_border = (r_px == '0) || (r_py == '0);

  always_comb begin
    w_fill = 3'b001;
    case (r_code)
      2'd0:    w_fill = 3'b001;
      2'd1:    w_fill = 3'b010;
      2'd2:    w_fill = 3'b111;
      default: w_fill = 3'b100;
    endcase
  end

  // Pixel outputs are forced to zero outside DRAW so idle reads as all-zero
  assign cell_board = r_board;
  assign cell_x     = r_cx;
  assign cell_y     = r_cy;
  assign pix_valid  = w_draw;
  assign pix_x      = w_draw ? 9'(X0 + 32'(r_board) * BOARD_PITCH + 32'(r_cx) * CELL_PX
                                  + 32'(r_px)) : 9'd0;
  assign pix_y      = w_draw ? 8'(Y0 + 32'(r_cy) * CELL_PX + 32'(r_py)) : 8'd0;
  assign pix_colour = !w_draw ? 3'b000 : (w_border ? (r_hit ? 3'b110 : 3'b000) : w_fill);
  assign BUSY       = (r_state == S_LOAD) || w_draw;
  assign DONE       = (r_state == S_FIN);

endmodule

// File: tb/tb_board_scan_renderer.sv
// Randomized scoreboard bench: a frame-level model queues every expected pixel,
// a monitor pops and compares on each accepted handshake.
module tb_board_scan_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, s_start, ready;
  logic [1:0] cb, code, cen;
  logic [3:0] cxo, cyo, cux, cuy, cux_d, cuy_d;
  logic [8:0] px;
  logic [7:0] py;
  logic [2:0] col;
  logic       pv, busy, done;

  logic [1:0] tbl [0:511];
  logic [1:0] noise = 2'd0;
  logic [3:0] nx = 4'd0, ny = 4'd0;

  // Garbage on code/cursor while drawing: the DUT must use its latched copy
  assign code  = pv ? noise : tbl[{cb[0], cyo, cxo}];
  assign cux_d = pv ? nx : cux;
  assign cuy_d = pv ? ny : cuy;

  board_scan_renderer dut (
    .CLOCK(clk), .RESET(rst), .START(start),
    .cell_board(cb), .cell_x(cxo), .cell_y(cyo), .cell_code(code),
    .cursor_en(cen), .cursor_x(cux_d), .cursor_y(cuy_d),
    .pix_x(px), .pix_y(py), .pix_colour(col), .pix_valid(pv), .pix_ready(ready),
    .BUSY(busy), .DONE(done)
  );

  logic [1:0] s_cb;
  logic [3:0] s_cx, s_cy;
  logic [8:0] s_px;
  logic [7:0] s_py;
  logic [2:0] s_col;
  logic       s_pv, s_busy, s_done;

  board_scan_renderer #(.GRID_W(4), .GRID_H(3), .CELL_PX(4), .NUM_BOARDS(1)) dut_s (
    .CLOCK(clk), .RESET(rst), .START(s_start),
    .cell_board(s_cb), .cell_x(s_cx), .cell_y(s_cy), .cell_code(2'd0),
    .cursor_en(1'b0), .cursor_x(4'd0), .cursor_y(4'd0),
    .pix_x(s_px), .pix_y(s_py), .pix_colour(s_col), .pix_valid(s_pv), .pix_ready(1'b1),
    .BUSY(s_busy), .DONE(s_done)
  );

  int cyc = 0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= 2'($urandom);
    nx    <= 4'($urandom);
    ny    <= 4'($urandom);
  end

  logic [19:0] expq[$];
  int n_vec = 0, n_err = 0;
  int frame_no = 0, pix_idx = 0, stalls = 0, start_cyc = 0, s_start_cyc = 0, s_pix = 0;
  bit expect_done = 0, done_seen = 0, s_done_seen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (frame %0d, pixel %0d)", nm, act, exp, frame_no, pix_idx);
    end
  endtask

  // Reference: walk the frame in display order and compute every pixel
  task automatic push_frame();
    int x, y;
    logic [1:0] c;
    logic [2:0] colr;
    bit hit;
    expq.delete();
    for (int b = 0; b < 2; b++)
      for (int gy = 0; gy < 10; gy++)
        for (int gx = 0; gx < 10; gx++)
          for (int oy = 0; oy < 8; oy++)
            for (int ox = 0; ox < 8; ox++) begin
              x   = (b * 160 + gx * 8 + ox) % 512;
              y   = (20 + gy * 8 + oy) % 256;
              c   = tbl[b * 256 + gy * 16 + gx];
              hit = cen[b] && (int'(cux) == gx) && (int'(cuy) == gy);
              if (ox == 0 || oy == 0) colr = hit ? 3'b110 : 3'b000;
              else case (c)
                2'd0: colr = 3'b001;
                2'd1: colr = 3'b010;
                2'd2: colr = 3'b111;
                default: colr = 3'b100;
              endcase
              expq.push_back({9'(x), 8'(y), colr});
            end
  endtask

  // Main monitor: pixels, hold stability, DONE timing
  initial begin
    bit hold = 0;
    logic [20:0] held = '0;
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (rst) hold = 0;
      else begin
        if (hold) check("hold_stable", 32'({pv, px, py, col}), 32'(held));
        hold = 0;
        if (pv && !ready) begin
          hold = 1;
          held = {pv, px, py, col};
          stalls++;
        end
        if (pv && ready) begin
          if (expq.size() == 0) check("extra_pixel", 1, 0);
          else begin
            e = expq.pop_front();
            check("pixel", 32'({px, py, col}), 32'(e));
          end
          if (pix_idx == 0) check("first_pixel", 32'({px, py}), 32'({9'd0, 8'd20}));
          if (frame_no == 0) begin
            if (pix_idx == 0)     check("pix0",  32'({px, py, col}), 32'({9'd0, 8'd20, 3'b000}));
            if (pix_idx == 9)     check("pix9",  32'({px, py, col}), 32'({9'd1, 8'd21, 3'b001}));
            if (pix_idx == 12799) check("pixlast", 32'({px, py, col}), 32'({9'd239, 8'd99, 3'b001}));
          end
          if (frame_no == 1) begin
            if (px == 9'd180 && py == 8'd47) check("hit_interior", 32'(col), 32'd4);
            if (px == 9'd176 && py == 8'd44) check("hit_border", 32'(col), 32'd0);
            if (px == 9'd72  && py == 8'd92) check("cursor_border", 32'(col), 32'd6);
            if (px == 9'd232 && py == 8'd92) check("b1_no_cursor", 32'(col), 32'd0);
          end
          pix_idx++;
        end
        if (done) begin
          check("done_expected", 32'(expect_done), 1);
          check("done_pixels", 32'(pix_idx), 32'd12800);
          check("done_queue_empty", 32'(expq.size()), 0);
          check("done_cycle", 32'(cyc - start_cyc), 32'(13001 + stalls));
          expect_done = 0;
          done_seen   = 1;
        end
      end
    end
  end

  // Small-geometry instance: pixel count and DONE latency
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (s_pv) s_pix++;
      if (s_done) begin
        check("small_pixels", 32'(s_pix), 32'd192);
        check("small_done_cycle", 32'(cyc - s_start_cyc), 32'd205);
        s_done_seen = 1;
        s_pix = 0;
      end
    end
  end

  task automatic run_frame(input int mode, input bit stray, input bit do_reset, input bit fin_start);
    push_frame();
    pix_idx = 0; stalls = 0; done_seen = 0; expect_done = 1;
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc;
    if (frame_no == 0) begin s_start = 1'b1; s_start_cyc = cyc; end
    for (int i = 0; i < 20000 && !done_seen; i++) begin
      @(posedge clk); #1;
      start = 1'b0; s_start = 1'b0;
      case (mode)
        0: ready = 1'b1;
        1: ready = !(i >= 100 && i < 105);
        default: ready = ($urandom_range(0, 6) != 0);
      endcase
      if (stray && i == 3000) start = 1'b1;
      if (frame_no == 0 && i == 50) s_start = 1'b1;
      if (do_reset && i == 9000) begin
        check("reset_in_board1", 32'({cb, pv}), 32'({2'd1, 1'b1}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_done = 0;
        expq.delete();
        @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(pv), 0);
        check("reset_done", 32'(done), 0);
        repeat (20) @(posedge clk);
        return;
      end
      @(negedge clk);
      if (fin_start && done) start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (!done_seen) check("done_timeout", 0, 1);
    if (mode == 1) check("stall_count", 32'(stalls), 32'd5);
    if (fin_start) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("fin_start_ignored", 32'({busy, pv}), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_start = 1'b0; ready = 1'b0;
    cen = '0; cux = '0; cuy = '0;
    for (int i = 0; i < 512; i++) tbl[i] = 2'd0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outs_a", 32'({cb, cxo, cyo, pv, busy, done}), 0);
    check("reset_outs_b", 32'({px, py, col}), 0);

    frame_no = 0;
    run_frame(0, 0, 0, 0);

    frame_no = 1;
    tbl[256 + 3 * 16 + 2] = 2'd3;
    cen = 2'b01; cux = 4'd9; cuy = 4'd9;
    run_frame(1, 0, 0, 0);

    for (int f = 2; f < 5; f++) begin
      frame_no = f;
      for (int i = 0; i < 512; i++) tbl[i] = 2'($urandom);
      cen = 2'($urandom);
      cux = 4'($urandom_range(0, 9));
      cuy = 4'($urandom_range(0, 9));
      run_frame(2, f == 2, f == 3, f == 4);
    end

    check("small_done_seen", 32'(s_done_seen), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete (vectors %0d)", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
